// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the bit-counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only needs to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit subtractor cells: a half subtractor and the full
// subtractor composed from two of them, mirroring the adder structure.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference;
  // its borrow term reduces to ~(a^b)&bin.
  half_subtractor u_hs1 (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with a start/ready handshake and a one-cycle done pulse.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-2:0] res_sr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             ovf_reg;

  logic             fs_d;
  logic             fs_bo;
  logic             last_bit;
  logic [WIDTH-1:0] res_cat;

  full_subtractor u_fs (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .bin  (borrow_reg),
    .diff (fs_d),
    .bout (fs_bo)
  );

  assign last_bit = (cnt_reg == LAST_CNT);
  // On the last RUN edge the new bit completes the result: it becomes the MSB.
  assign res_cat  = {fs_d, res_sr_reg};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_in) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state_reg == IDLE);
    busy_out  = (state_reg == RUN);
    done_out  = (state_reg == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      res_sr_reg     <= '0;
      cnt_reg        <= '0;
      borrow_reg     <= 1'b0;
      a_msb_reg      <= 1'b0;
      b_msb_reg      <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            a_sr_reg   <= a_in;
            b_sr_reg   <= b_in;
            borrow_reg <= bin_in;
            cnt_reg    <= '0;
            a_msb_reg  <= a_in[WIDTH-1];
            b_msb_reg  <= b_in[WIDTH-1];
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= res_cat[WIDTH-1:1];
          borrow_reg <= fs_bo;
          cnt_reg    <= cnt_reg + 1'b1;
          // Result registers change only here, so no partial value is visible.
          if (last_bit) begin
            diff_reg       <= res_cat;
            borrow_out_reg <= fs_bo;
            ovf_reg        <= (a_msb_reg != b_msb_reg) && (fs_d != a_msb_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff_out   = diff_reg;
  assign borrow_out = borrow_out_reg;
  assign ovf_out    = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed corner cases plus random
// operands, checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
  logic             ovf_out;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin_in     (bin_in),
    .ready_out  (ready_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .ovf_out    (ovf_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    int               done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   pushed    = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer subtraction, reduced modulo 2^WIDTH.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t e;
    int   ai, bi, d;
    ai = int'(a);
    bi = int'(b);
    d  = ai - bi - int'(bin);
    e.diff     = WIDTH'(d);
    e.borrow   = (ai < bi + int'(bin));
    e.ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  exp_t mon_e;
  logic prev_done = 1'b0;
  always @(negedge clk_in) begin
    if (prev_done) begin
      check("ready_after_done", ready_out, 1'b1);
      check("done_single_pulse", done_out, 1'b0);
    end
    prev_done = done_out;
    if (done_out) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done with diff=%0h, expected no done", diff_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", diff_out, mon_e.diff);
        check("borrow", borrow_out, mon_e.borrow);
        check("ovf", ovf_out, mon_e.ovf);
        check("latency", cyc, mon_e.done_cyc);
        $display("[TB] result diff=%02h borrow=%0b ovf=%0b at cycle %0d",
                 diff_out, borrow_out, ovf_out, cyc);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: ready timeout, got ready=0, expected 1", name);
    end
  endtask

  // inject: pulse a second start in RUN cycle 3. abort_at>0: reset in that RUN cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input bit inject, input int abort_at);
    exp_t e;
    wait_ready("wait_idle");
    @(negedge clk_in);
    a_in     = a;
    b_in     = b;
    bin_in   = bin;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    a_in     = WIDTH'($urandom);
    b_in     = WIDTH'($urandom);
    bin_in   = 1'($urandom);
    e = model(a, b, bin);
    e.done_cyc = cyc + WIDTH;
    if (abort_at == 0) begin
      sb_q.push_back(e);
      pushed++;
    end
    check("busy_in_run", busy_out, 1'b1);
    check("ready_in_run", ready_out, 1'b0);
    if (inject) begin
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      a_in     = '1;
      b_in     = '1;
      bin_in   = 1'b0;
      start_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check("rst_ready", ready_out, 1'b1);
      check("rst_busy", busy_out, 1'b0);
      check("rst_done", done_out, 1'b0);
      check("rst_diff", diff_out, '0);
      check("rst_borrow", borrow_out, 1'b0);
      check("rst_ovf", ovf_out, 1'b0);
      $display("[TB] op %02h-%02h-%0b aborted by reset", a, b, bin);
    end else begin
      @(negedge clk_in);
      wait_ready("op_complete");
      check("diff_held", diff_out, e.diff);
      $display("[TB] op %02h-%02h-%0b issued", a, b, bin);
    end
  endtask

  initial begin
    rst_in   = 1'b1;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    bin_in   = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_ready", ready_out, 1'b1);
    check("reset_busy", busy_out, 1'b0);
    check("reset_done", done_out, 1'b0);
    check("reset_diff", diff_out, '0);
    check("reset_borrow", borrow_out, 1'b0);
    check("reset_ovf", ovf_out, 1'b0);
    rst_in = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0, 0);
    run_op(8'h10, 8'h0F, 1'b1, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h20, 8'h01, 1'b0, 1'b1, 0);
    run_op(8'h05, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h44, 8'h11, 1'b0, 1'b0, 4);
    run_op(8'h44, 8'h11, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk_in);
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 0);
    end

    repeat (WIDTH + 4) @(posedge clk_in);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    check("done_count", done_seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
